// File: rtl/flag_channel_arbiter.sv
// flag_channel_arbiter: round-robin share of one flag/ack crossing among NUM_REQ requesters.
module flag_channel_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W = 10
) (
  input  logic               clkA,
  input  logic               rst_clkA,
  input  logic [NUM_REQ-1:0] Req_clkA,
  output logic [NUM_REQ-1:0] Grant_clkA,
  output logic [TAG_W-1:0]   Tag_clkA,
  output logic [NUM_REQ-1:0] Done_clkA,
  output logic [NUM_REQ-1:0] Err_clkA,
  output logic               ErrSticky_clkA,
  output logic               FlagOut_clkA,
  input  logic               BusyIn_clkA,
  output logic [15:0]        XferCount_clkA
);
  localparam int PTR_W = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, RECOVER} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d, err_q, err_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, pick, idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0] xfer_q, xfer_d;
  logic sticky_q, sticky_d, flag_q, flag_d, found, tmo;
  // first requester strictly after the last owner, wrapping
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && Req_clkA[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clkA) begin
    if (rst_clkA) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q <= '0;
      err_q <= '0;
      tag_q <= '0;
      ptr_q <= PTR_W'(NUM_REQ - 1);
      cnt_q <= '0;
      xfer_q <= '0;
      sticky_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q <= done_d;
      err_q <= err_d;
      tag_q <= tag_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      xfer_q <= xfer_d;
      sticky_q <= sticky_d;
      flag_q <= flag_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (found && !BusyIn_clkA) ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT_HI;
      WAIT_HI: state_d = BusyIn_clkA ? WAIT_LO : (tmo ? RECOVER : WAIT_HI);
      WAIT_LO: state_d = !BusyIn_clkA ? IDLE : (tmo ? RECOVER : WAIT_LO);
      RECOVER: state_d = BusyIn_clkA ? RECOVER : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    grant_d = grant_q;
    tag_d = tag_q;
    ptr_d = ptr_q;
    xfer_d = xfer_q;
    sticky_d = sticky_q;
    flag_d = 1'b0;
    done_d = '0;
    err_d = '0;
    cnt_d = (state_q == WAIT_HI || state_q == WAIT_LO) ? cnt_q + 1'b1 : cnt_q;
    if (state_q == IDLE && state_d == ISSUE) begin
      grant_d = NUM_REQ'(1) << pick;
      tag_d = TAG_W'(pick);
      flag_d = 1'b1;
      cnt_d = '0;
    end
    if (state_q == WAIT_LO && state_d == IDLE) begin
      done_d = grant_q;
      grant_d = '0;
      xfer_d = xfer_q + 16'd1;
      ptr_d = tag_q[PTR_W-1:0];
    end
    if (state_q != RECOVER && state_d == RECOVER) begin
      err_d = grant_q;
      sticky_d = 1'b1;
      grant_d = '0;
      ptr_d = tag_q[PTR_W-1:0];
    end
  end
  assign Grant_clkA = grant_q;
  assign Tag_clkA = tag_q;
  assign Done_clkA = done_q;
  assign Err_clkA = err_q;
  assign ErrSticky_clkA = sticky_q;
  assign FlagOut_clkA = flag_q;
  assign XferCount_clkA = xfer_q;
endmodule

// File: tb/tb_flag_channel_arbiter.sv
// tb_flag_channel_arbiter: randomized scenario bench with a transaction-level round-robin model.
module tb_flag_channel_arbiter;
  localparam int N = 4;
  localparam int TW = 2;
  logic clk = 1'b0, rst = 1'b1, busy = 1'b0, sticky, flag;
  logic [N-1:0] req = '0, grant, done, err;
  logic [TW-1:0] tag;
  logic [15:0] xcnt;
  int checks = 0, fails = 0, exp_ptr = N - 1, exp_xfer = 0;
  flag_channel_arbiter #(.NUM_REQ(N), .TAG_W(TW), .TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clkA(clk), .rst_clkA(rst), .Req_clkA(req), .Grant_clkA(grant), .Tag_clkA(tag),
    .Done_clkA(done), .Err_clkA(err), .ErrSticky_clkA(sticky), .FlagOut_clkA(flag),
    .BusyIn_clkA(busy), .XferCount_clkA(xcnt));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic xfer(input int rise, input int hold, input logic [N-1:0] wd, input logic [N-1:0] clr);
    int own, w;
    logic [N-1:0] eg;
    own = pick(req, exp_ptr);
    eg = N'(1) << own;
    w = 0;
    while (grant == '0 && w < 20) begin tick; w++; end
    checks++;
    if (grant == '0) begin fails++; $display("FAIL grant_wait: no grant in 20 cycles, req=%b", req); return; end
    checks++;
    if ({grant, tag, flag} !== {eg, TW'(own), 1'b1})
      begin fails++; $display("FAIL grant: grant=%b tag=%0d flag=%b, want %b %0d 1", grant, tag, flag, eg, own); end
    tick;
    checks++;
    if ({flag, grant} !== {1'b0, eg})
      begin fails++; $display("FAIL flag_pulse: flag=%b grant=%b, want 0 %b", flag, grant, eg); end
    req &= ~wd;
    repeat (rise - 1) tick;
    busy = 1'b1;
    repeat (hold) begin
      tick;
      checks++;
      if ({done, err, grant} !== {N'(0), N'(0), eg})
        begin fails++; $display("FAIL busy_phase: done=%b err=%b grant=%b, want 0 0 %b", done, err, grant, eg); end
    end
    busy = 1'b0;
    tick;
    exp_xfer++;
    exp_ptr = own;
    checks++;
    if ({done, err, grant, tag, xcnt} !== {eg, N'(0), N'(0), TW'(own), 16'(exp_xfer)})
      begin fails++; $display("FAIL done: done=%b err=%b grant=%b tag=%0d cnt=%0d, want %b 0 0 %0d %0d", done, err, grant, tag, xcnt, eg, own, exp_xfer); end
    req &= ~clr;
    tick;
    checks++;
    if (done !== '0) begin fails++; $display("FAIL done_pulse: done=%b, want 0", done); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if ({grant, tag, done, err, sticky, flag, xcnt} !== '0)
      begin fails++; $display("FAIL reset: grant=%b tag=%0d done=%b err=%b sticky=%b flag=%b cnt=%0d, want all 0", grant, tag, done, err, sticky, flag, xcnt); end
    rst = 1'b0;
    tick;
  endtask
  task automatic test_round_robin;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) xfer(int'($urandom_range(1, 2)), int'($urandom_range(1, 5)), '0, i == 4 ? 4'b1111 : 4'b0000);
    checks++;
    if (xcnt !== 16'd5) begin fails++; $display("FAIL rr_count: cnt=%0d, want 5", xcnt); end
  endtask
  task automatic test_single;
    req = 4'b0001;
    tick;
    checks++;
    if (grant !== 4'b0001) begin fails++; $display("FAIL grant_latency: grant=%b, want 0001", grant); end
    xfer(1, 6, '0, 4'b0001);
  endtask
  task automatic test_busy_guard;
    busy = 1'b1;
    req = 4'b0010;
    repeat (5) begin
      tick;
      checks++;
      if ({grant, flag} !== '0) begin fails++; $display("FAIL busy_guard: grant=%b flag=%b, want 0 0", grant, flag); end
    end
    busy = 1'b0;
    tick;
    checks++;
    if (grant !== 4'b0010) begin fails++; $display("FAIL guard_release: grant=%b, want 0010", grant); end
    xfer(1, 3, '0, 4'b0010);
  endtask
  task automatic test_timeout;
    int w;
    req = 4'b0001;
    w = 0;
    while (grant == '0 && w < 20) begin tick; w++; end
    checks++;
    if (grant !== 4'b0001) begin fails++; $display("FAIL to_grant: grant=%b, want 0001", grant); end
    tick;
    busy = 1'b1;
    repeat (7) begin
      tick;
      checks++;
      if (err !== '0) begin fails++; $display("FAIL to_early: err=%b, want 0", err); end
    end
    tick;
    exp_ptr = 0;
    checks++;
    if ({err, sticky, grant, done, xcnt} !== {4'b0001, 1'b1, N'(0), N'(0), 16'(exp_xfer)})
      begin fails++; $display("FAIL timeout: err=%b sticky=%b grant=%b done=%b cnt=%0d, want 0001 1 0 0 %0d", err, sticky, grant, done, xcnt, exp_xfer); end
    tick;
    checks++;
    if (err !== '0) begin fails++; $display("FAIL err_pulse: err=%b, want 0", err); end
    repeat (3) begin
      tick;
      checks++;
      if (grant !== '0) begin fails++; $display("FAIL recover_hold: grant=%b, want 0", grant); end
    end
    busy = 1'b0;
    tick;
    checks++;
    if (grant !== '0) begin fails++; $display("FAIL recover_exit: grant=%b, want 0", grant); end
    tick;
    checks++;
    if (grant !== 4'b0001) begin fails++; $display("FAIL post_recover: grant=%b, want 0001", grant); end
    xfer(1, 2, '0, 4'b0001);
    checks++;
    if (sticky !== 1'b1) begin fails++; $display("FAIL sticky_hold: sticky=%b, want 1", sticky); end
  endtask
  task automatic test_withdraw;
    req = 4'b0010;
    xfer(1, 3, 4'b0010, '0);
    repeat (4) begin
      tick;
      checks++;
      if (grant !== '0) begin fails++; $display("FAIL withdraw_regrant: grant=%b, want 0", grant); end
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      req = N'($urandom_range(1, 15));
      xfer(int'($urandom_range(1, 2)), int'($urandom_range(1, 5)), ($urandom % 2) ? req : '0, 4'b1111);
    end
  endtask
  task automatic test_reset_mid;
    int w;
    req = 4'b0100;
    w = 0;
    while (grant == '0 && w < 20) begin tick; w++; end
    checks++;
    if (grant !== 4'b0100) begin fails++; $display("FAIL rm_grant: grant=%b, want 0100", grant); end
    tick;
    busy = 1'b1;
    repeat (2) tick;
    rst = 1'b1;
    tick;
    checks++;
    if ({grant, tag, done, err, sticky, flag, xcnt} !== '0)
      begin fails++; $display("FAIL mid_reset: grant=%b tag=%0d done=%b err=%b sticky=%b flag=%b cnt=%0d, want all 0", grant, tag, done, err, sticky, flag, xcnt); end
    rst = 1'b0;
    exp_ptr = N - 1;
    exp_xfer = 0;
    repeat (3) begin
      tick;
      checks++;
      if ({grant, flag} !== '0) begin fails++; $display("FAIL drain_guard: grant=%b flag=%b, want 0 0", grant, flag); end
    end
    busy = 1'b0;
    tick;
    checks++;
    if ({grant, tag} !== {4'b0100, 2'd2}) begin fails++; $display("FAIL drain_grant: grant=%b tag=%0d, want 0100 2", grant, tag); end
    xfer(1, 2, '0, 4'b0100);
  endtask
  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_busy_guard;
    test_timeout;
    test_withdraw;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
